// File: rtl/residual_add_pack.sv
// Residual add (a + b, signed) packed into a SEQ_LEN x EMB_DIM frame for layer norm.
// Define RESADD_SAT_EN to clamp overflowing sums; otherwise they wrap.
module residual_add_pack #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_WIDTH-1:0]                     in_a,
    input  logic [DATA_WIDTH-1:0]                     in_b,
    input  logic                                      in_last,
    output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]     x_out,
    output logic                                      ln_start,
    input  logic                                      ln_done,
    output logic                                      frame_err,
    output logic [$clog2(SEQ_LEN*EMB_DIM):0]          ovf_cnt
);

    localparam int N     = SEQ_LEN * EMB_DIM;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N) + 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]      OVF_MAX  = CNT_W'(N);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [DATA_WIDTH*N-1:0]       frame_buf;
    logic [DATA_WIDTH:0]           sum_ext;
    logic                          overflow;
    logic [DATA_WIDTH-1:0]         store_val;
    logic                          accept;
    logic                          is_last;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum_ext   = {in_a[DATA_WIDTH-1], in_a} + {in_b[DATA_WIDTH-1], in_b};
        overflow  = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
`ifdef RESADD_SAT_EN
        store_val = overflow ? (sum_ext[DATA_WIDTH] ? MIN_VAL : MAX_VAL)
                             : sum_ext[DATA_WIDTH-1:0];
`else
        store_val = sum_ext[DATA_WIDTH-1:0];
`endif
    end

    assign in_ready = (state == S_FILL);
    assign accept   = in_valid && in_ready;
    assign is_last  = (idx == LAST_IDX);
    assign x_out    = frame_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            idx       <= '0;
            frame_buf <= '0;
            ln_start  <= 1'b0;
            frame_err <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            ln_start  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        frame_buf[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= store_val;
                        // in_last only flags a framing error; frame length stays fixed at N.
                        frame_err <= (in_last != is_last);
                        if (overflow && (ovf_cnt != OVF_MAX)) begin
                            ovf_cnt <= ovf_cnt + 1'b1;
                        end
                        if (is_last) begin
                            idx      <= '0;
                            state    <= S_LAUNCH;
                            ln_start <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ln_done) begin
                        state   <= S_FILL;
                        ovf_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_residual_add_pack.sv
// Randomized self-checking bench for residual_add_pack against a simple array model.
// Honors RESADD_SAT_EN the same way the design does.
module tb_residual_add_pack;

    localparam int DW = 16;
    localparam int N  = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic            in_last = 1'b0;
    logic [DW*N-1:0] x_out;
    logic            ln_start;
    logic            ln_done = 1'b0;
    logic            frame_err;
    logic [6:0]      ovf_cnt;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_buf [N];
    int            idx_m = 0;
    int            ovf_m = 0;

    residual_add_pack #(.DATA_WIDTH(DW), .SEQ_LEN(8), .EMB_DIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .x_out(x_out),
        .ln_start(ln_start), .ln_done(ln_done), .frame_err(frame_err),
        .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference sum from integer arithmetic on the signed operands.
    function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              output bit ovf);
        int s;
        s   = int'($signed(a)) + int'($signed(b));
        ovf = (s > 32767) || (s < -32768);
`ifdef RESADD_SAT_EN
        if (s > 32767)       return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else                 return 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic doReset();
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        ln_done  = 1'b0;
        #2;
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_x_zero", (x_out == '0), 1);
        checkOutput("rst_start", ln_start, 0);
        checkOutput("rst_ovf", ovf_cnt, 0);
        checkOutput("rst_err", frame_err, 0);
        for (int k = 0; k < N; k++) exp_buf[k] = '0;
        idx_m = 0;
        ovf_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int cycles, input bit pulse_done);
        for (int i = 0; i < cycles; i++) begin
            ln_done = pulse_done;
            @(posedge clk);
            #1;
            ln_done = 1'b0;
            checkOutput("idle_ready", in_ready, 1);
            checkOutput("idle_start", ln_start, 0);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic last);
        int  waited;
        int  k;
        bit  ovf;
        bit  exp_err;
        bit  exp_start;
        waited   = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k          = idx_m;
        exp_buf[k] = ref_sum(a, b, ovf);
        if (ovf && ovf_m < N) ovf_m++;
        exp_start = (k == N - 1);
        exp_err   = (last != exp_start);
        idx_m     = exp_start ? 0 : k + 1;
        checkOutput("elem", x_out[k*DW +: DW], exp_buf[k]);
        checkOutput("frame_err", frame_err, exp_err);
        checkOutput("ln_start", ln_start, exp_start);
        checkOutput("ovf_cnt", ovf_cnt, ovf_m);
        checkOutput("beat_ready", in_ready, !exp_start);
    endtask

    // pat 0: a=k,b=100; pat 1: overflow corner beats then random; pat 2: random.
    task automatic runFrame(input int pat, input int err_beat, input bit drop_last,
                            input int gap_max, input bit done_in_launch, input bit release_fill);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
        for (int k = 0; k < N; k++) begin
            if (gap_max > 0) idleCycles($urandom_range(0, gap_max), 1'($urandom_range(0, 1)));
            if (pat == 0) begin
                a = 16'(k);
                b = 16'd100;
            end else if (pat == 1 && k == 0) begin
                a = 16'h7FFF;
                b = 16'h0001;
            end else if (pat == 1 && k == 1) begin
                a = 16'h8000;
                b = 16'hFFFF;
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            last = (k == err_beat) || (k == N - 1 && !drop_last);
            applyStimulus(a, b, last);
            if (pat == 1 && k == 0) begin
                checkOutput("ovf_first", ovf_cnt, 1);
`ifdef RESADD_SAT_EN
                checkOutput("sat_pos", x_out[DW-1:0], 16'h7FFF);
`else
                checkOutput("wrap_pos", x_out[DW-1:0], 16'h8000);
`endif
            end
            if (pat == 1 && k == 1) begin
                checkOutput("ovf_second", ovf_cnt, 2);
`ifdef RESADD_SAT_EN
                checkOutput("sat_neg", x_out[2*DW-1:DW], 16'h8000);
`else
                checkOutput("wrap_neg", x_out[2*DW-1:DW], 16'h7FFF);
`endif
            end
        end
        ln_done = done_in_launch;
        @(posedge clk);
        #1;
        ln_done = 1'b0;
        checkOutput("wait_ready", in_ready, 0);
        checkOutput("wait_start", ln_start, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_ready", in_ready, 0);
        end
        for (int k = 0; k < N; k++) begin
            checkOutput("frame_elem", x_out[k*DW +: DW], exp_buf[k]);
            if (pat == 0) checkOutput("ramp_elem", x_out[k*DW +: DW], 16'(k + 100));
        end
        checkOutput("frame_ovf", ovf_cnt, ovf_m);
        if (release_fill) begin
            ln_done = 1'b1;
            @(posedge clk);
            #1;
            ln_done = 1'b0;
            ovf_m = 0;
            checkOutput("resume_ready", in_ready, 1);
            checkOutput("resume_ovf", ovf_cnt, 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        doReset();
        runFrame(0, -1, 1'b0, 0, 1'b0, 1'b1);
        runFrame(1, -1, 1'b0, 0, 1'b0, 1'b1);
        runFrame(2, 10, 1'b1, 0, 1'b0, 1'b1);
        runFrame(2, -1, 1'b0, 3, 1'b1, 1'b1);
        runFrame(2, -1, 1'b0, 2, 1'b0, 1'b1);
        runFrame(2, -1, 1'b0, 0, 1'b0, 1'b0);
        doReset();
        for (int k = 0; k < 30; k++) applyStimulus(16'($urandom), 16'($urandom), 1'b0);
        doReset();
        runFrame(0, -1, 1'b0, 1, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/residual_add_pack.md
# residual_add_pack

Residual-add and frame-packing stage directly upstream of the layer-norm stage in the transformer datapath. Accepts a row-major element stream of sublayer outputs (`in_a`) and skip-path values (`in_b`) over a valid/ready handshake, and adds each pair in signed fixed point. Results are packed into a flattened SEQ_LEN×EMB_DIM matrix that drives the layer-norm `x_in`. When a full frame is assembled, the block issues a one-cycle start pulse, then holds the matrix stable until the layer-norm stage reports done.

## Interface
- `DATA_WIDTH`, 16, element width; signed two's complement.
- `SEQ_LEN`, 8, rows (tokens) per frame.
- `EMB_DIM`, 8, columns per row; N = SEQ_LEN*EMB_DIM elements per frame.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_a` in DATA_WIDTH: sublayer output element.
- `in_b` in DATA_WIDTH: residual (skip) element.
- `in_last` in 1: marks the final element (index N-1) of a frame.
- `x_out` out DATA_WIDTH*N: packed matrix; element k = row*EMB_DIM+col at bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- `ln_start` out 1: one-cycle start pulse to layer norm.
- `ln_done` in 1: layer-norm completion pulse.
- `frame_err` out 1: one-cycle pulse on an `in_last` mismatch.
- `ovf_cnt` out $clog2(N)+1: count of overflowing adds in the current/last frame.

## Operation
- States: S_FILL, S_LAUNCH, S_WAIT. Reset state is S_FILL.
- **S_FILL**
  - `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`.
  - On acceptance: buf[idx] <= sum(in_a, in_b), then idx++.
  - The accept with idx==N-1 sets idx <= 0 and moves to S_LAUNCH.
- **S_LAUNCH**
  - `ln_start`=1 for exactly this cycle; next state is S_WAIT.
  - `ln_done` is ignored here.
- **S_WAIT**
  - `in_ready`=0.
  - `ln_done`=1 moves to S_FILL and clears `ovf_cnt`.
- `ln_done` is ignored in S_FILL.
- **Arithmetic**
  - Sign-extend both operands to DATA_WIDTH+1 and add.
  - Overflow when the result is outside [-2^(DW-1), 2^(DW-1)-1].
  - On overflow, `ovf_cnt` increments, saturating at N.
  - The stored value depends on the configuration macro below.
- **Frame check**
  - `in_last`=1 on an accepted beat with idx≠N-1 pulses `frame_err` the next cycle. The beat is still stored and counting continues.
  - `in_last`=0 on the accepted beat with idx==N-1 also pulses `frame_err`. The frame still completes.
  - Frame length is always N beats; `in_last` never truncates or extends a frame.
- `x_out` is driven directly by buf. It changes only on accepted beats, so it is stable throughout S_LAUNCH and S_WAIT.
- **Reset mid-operation** (any state): buf=0, idx=0, state S_FILL. A pending `ln_done` is lost and the partial frame is discarded.

## Timing
- Reset values:
  - `in_ready`=1 (derived combinationally from state==S_FILL).
  - `ln_start`=0, `frame_err`=0, `ovf_cnt`=0, `x_out`=0.
- Write latency: a beat accepted at cycle T is visible on `x_out` at T+1.
- Launch sequence:
  - Last beat accepted at T.
  - `ln_start` high during T+1 (state S_LAUNCH).
  - `in_ready`=0 from T+1.
- Resume: `ln_done` sampled high at cycle D gives S_FILL and `in_ready`=1 at D+1. The first new beat can be accepted at D+1.
- Throughput in S_FILL is one beat per cycle; `in_valid` may idle arbitrarily between beats.
- Upstream must hold `in_a`/`in_b`/`in_last` while `in_valid`=1 and `in_ready`=0.

## Configuration
- `RESADD_SAT_EN` defined: overflowing sums are stored clamped to 2^(DW-1)-1 or -2^(DW-1).
- `RESADD_SAT_EN` undefined: overflowing sums wrap (the low DATA_WIDTH bits are stored).
- `ovf_cnt` counts overflows in both builds.

## Test plan
- Reset, then check all outputs: `in_ready`=1, `x_out`=0, `ln_start`=0, `ovf_cnt`=0.
- Stream 64 beats, a=k, b=100, `in_last` on beat 63 → `x_out` element k = k+100; one `ln_start` pulse the cycle after beat 63; `in_ready`=0 until `ln_done`+1; `frame_err` never pulses.
- a=0x7FFF, b=0x0001 on beat 0:
  - With `RESADD_SAT_EN`: element 0 = 0x7FFF.
  - Without it: element 0 = 0x8000.
  - In both builds, `ovf_cnt`=1. Repeat with a=0x8000, b=0xFFFF → 0x8000 (sat) or 0x7FFF (wrap).
- `in_last`=1 on beat 10, and `in_last`=0 on beat 63 → `frame_err` pulses at beat10+1 and beat63+1; `ln_start` still fires after beat 63.
- Random `in_valid` gaps; `ln_done` asserted during S_LAUNCH and during S_FILL → both are ignored. A second `ln_done` in S_WAIT restarts fill, and the second frame overwrites `x_out` correctly.
- Deassert `rst_n` during S_WAIT and mid-fill (beat 30) → immediate return to reset values. The next 64-beat frame packs from idx 0.
